// File: rtl/mtm_alu_pkg.sv
// mtm_alu_pkg: opcodes, FSM states, error bytes and CRC4/CRC3 helpers shared by the MTM ALU controller
package mtm_alu_pkg;
  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } op_e;
  typedef enum logic [2:0] {
    COLLECT,
    CHECK,
    EXEC,
    SEND_RES,
    SEND_ERR
  } state_e;
  localparam logic [7:0] ERR_DATA = 8'hC9;
  localparam logic [7:0] ERR_CRC  = 8'hA5;
  localparam logic [7:0] ERR_OP   = 8'h93;
  function automatic logic op_ok(input logic [2:0] op);
    return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB};
  endfunction
  function automatic logic [3:0] crc4(input logic [67:0] d);
    logic [3:0] c;
    c = '0;
    for (int i = 67; i >= 0; i--) c = {c[2:0], 1'b0} ^ ({4{c[3] ^ d[i]}} & 4'b0011);
    return c;
  endfunction
  function automatic logic [2:0] crc3(input logic [36:0] d);
    logic [2:0] c;
    c = '0;
    for (int i = 36; i >= 0; i--) c = {c[1:0], 1'b0} ^ ({3{c[2] ^ d[i]}} & 3'b011);
    return c;
  endfunction
endpackage

// File: rtl/mtm_alu_crc.sv
// mtm_alu_crc: combinational CRC4 check of {A,B,1,OP} against crc_in (crc_ok) and CRC3 of {result,0,flags} (res_crc)
module mtm_alu_crc
  import mtm_alu_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  op,
  input  logic [3:0]  crc_in,
  input  logic [31:0] result,
  input  logic [3:0]  flags,
  output logic        crc_ok,
  output logic [2:0]  res_crc
);
  assign crc_ok  = crc4({data, 1'b1, op}) == crc_in;
  assign res_crc = crc3({result, 1'b0, flags});
endmodule

// File: rtl/mtm_alu_ctrl.sv
// mtm_alu_ctrl: packet controller -- rx packets (rx_valid/rx_cmd/rx_byte/rx_ready) drive ALU (alu_a/b/op/start, alu_valid/result/flags), replies on tx (tx_valid/ready/cmd/byte), busy outside COLLECT
module mtm_alu_ctrl
  import mtm_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic        rx_cmd,
  input  logic [7:0]  rx_byte,
  output logic        rx_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_start,
  input  logic        alu_valid,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        tx_cmd,
  output logic [7:0]  tx_byte,
  output logic        busy
);
  state_e      state, nxt;
  logic [63:0] data;
  logic [3:0]  cnt;
  logic [6:0]  ctl;
  logic [31:0] res;
  logic [3:0]  flg;
  logic [7:0]  err, err_c;
  logic [2:0]  idx, res_crc;
  logic        started, crc_ok, take;
  mtm_alu_crc u_crc (
    .data    (data),
    .op      (ctl[6:4]),
    .crc_in  (ctl[3:0]),
    .result  (res),
    .flags   (flg),
    .crc_ok  (crc_ok),
    .res_crc (res_crc)
  );
  assign take   = rx_ready && rx_valid;
  assign err_c  = cnt != 4'd8 ? ERR_DATA : !crc_ok ? ERR_CRC : op_ok(ctl[6:4]) ? 8'h00 : ERR_OP;
  assign alu_a  = data[63:32];
  assign alu_b  = data[31:0];
  assign alu_op = ctl[6:4];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= COLLECT;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      COLLECT:  nxt = take && rx_cmd ? CHECK : COLLECT;
      CHECK:    nxt = err_c != 8'h00 ? SEND_ERR : EXEC;
      EXEC:     nxt = alu_valid ? SEND_RES : EXEC;
      SEND_RES: nxt = tx_ready && idx == 3'd4 ? COLLECT : SEND_RES;
      SEND_ERR: nxt = tx_ready ? COLLECT : SEND_ERR;
      default:  nxt = COLLECT;
    endcase
  end
  always_comb begin
    rx_ready  = state == COLLECT;
    busy      = state != COLLECT;
    alu_start = state == EXEC && !started;
    tx_valid  = state == SEND_RES || state == SEND_ERR;
    tx_cmd    = state == SEND_ERR || (state == SEND_RES && idx == 3'd4);
    tx_byte   = state == SEND_ERR ? err :
                state != SEND_RES ? 8'h00 :
                idx == 3'd0 ? res[31:24] :
                idx == 3'd1 ? res[23:16] :
                idx == 3'd2 ? res[15:8] :
                idx == 3'd3 ? res[7:0] : {1'b0, flg, res_crc};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      data    <= '0;
      cnt     <= '0;
      ctl     <= '0;
      res     <= '0;
      flg     <= '0;
      err     <= '0;
      idx     <= '0;
      started <= 1'b0;
    end else begin
      started <= state == EXEC;
      if (take && !rx_cmd) begin
        data <= {data[55:0], rx_byte};
        cnt  <= cnt == 4'd9 ? cnt : cnt + 4'd1;
      end
      if (take && rx_cmd) ctl <= rx_byte[6:0];
      if (state == CHECK) err <= err_c;
      if (state == EXEC && alu_valid) begin
        res <= alu_result;
        flg <= alu_flags;
      end
      if (state == SEND_RES && tx_ready) idx <= idx == 3'd4 ? 3'd0 : idx + 3'd1;
      if (tx_valid && tx_ready && nxt == COLLECT) cnt <= '0;
    end
endmodule

// File: tb/tb_mtm_alu_ctrl.sv
// tb_mtm_alu_ctrl: directed self-checking bench for mtm_alu_ctrl with a small 2-cycle ALU responder
module tb_mtm_alu_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic        rx_cmd = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_ready;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_valid = 1'b0;
  logic [31:0] alu_result = '0;
  logic [3:0]  alu_flags = '0;
  logic        tx_valid, tx_cmd, busy;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_byte;
  int n_cmp = 0;
  int n_bad = 0;
  int starts = 0;
  int op_unstable = 0;
  logic [7:0] rb [0:4];
  logic       rc [0:4];
  bit stall_bad, busy_bad;

  mtm_alu_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rx_valid(rx_valid), .rx_cmd(rx_cmd), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_valid(alu_valid), .alu_result(alu_result), .alu_flags(alu_flags),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_cmd(tx_cmd), .tx_byte(tx_byte),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    int cd;
    logic [31:0] ma, mb, mr;
    logic [2:0]  mo;
    logic [32:0] w;
    logic [3:0]  mf;
    cd = 0;
    forever begin
      @(negedge clk);
      alu_valid = 1'b0;
      if (cd > 0) begin
        if (alu_a !== ma || alu_b !== mb || alu_op !== mo) op_unstable++;
        cd--;
        if (cd == 0) begin
          alu_valid  = 1'b1;
          alu_result = mr;
          alu_flags  = mf;
        end
      end
      if (alu_start === 1'b1) begin
        starts++;
        ma = alu_a;
        mb = alu_b;
        mo = alu_op;
        cd = 2;
        w  = mo == 3'b100 ? {1'b0, ma} + {1'b0, mb} :
             mo == 3'b101 ? {1'b0, ma} - {1'b0, mb} :
             mo == 3'b000 ? {1'b0, ma & mb} : {1'b0, ma | mb};
        mr = w[31:0];
        mf = {w[32],
              mo == 3'b100 ? (ma[31] == mb[31] && mr[31] != ma[31]) :
              mo == 3'b101 ? (ma[31] != mb[31] && mr[31] != ma[31]) : 1'b0,
              mr == 32'd0, mr[31]};
      end
    end
  end

  function automatic logic [3:0] ref_crc4(input logic [67:0] m);
    logic [71:0] r;
    r = {m, 4'b0000};
    for (int i = 71; i >= 4; i--) if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [2:0] ref_crc3(input logic [36:0] m);
    logic [39:0] r;
    r = {m, 3'b000};
    for (int i = 39; i >= 3; i--) if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1011;
    return r[2:0];
  endfunction

  function automatic logic [7:0] mk_ctl(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op, input logic [3:0] flip);
    return {1'b0, op, ref_crc4({a, b, 1'b1, op}) ^ flip};
  endfunction

  task automatic send_pkt(input logic cmd, input logic [7:0] b);
    rx_valid = 1'b1;
    rx_cmd   = cmd;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_cmd   = 1'b0;
    rx_byte  = 8'h00;
  endtask

  task automatic send_data(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 4; i++) send_pkt(1'b0, a[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) send_pkt(1'b0, b[31-8*i -: 8]);
  endtask

  task automatic recv(input int n, input int hold_at, input int hold_n, output int got, output int lat);
    int t, h;
    logic [7:0] ref_b;
    logic       ref_c;
    t = 0;
    h = hold_n;
    got = 0;
    lat = -1;
    ref_b = '0;
    ref_c = 1'b0;
    while (got < n && t < 300) begin
      if (tx_valid === 1'b1 && lat < 0) lat = t;
      if (got == hold_at && h > 0 && tx_valid === 1'b1) begin
        tx_ready = 1'b0;
        if (h == hold_n) begin
          ref_b = tx_byte;
          ref_c = tx_cmd;
        end else if (tx_byte !== ref_b || tx_cmd !== ref_c) stall_bad = 1'b1;
        if (rx_ready !== 1'b0 || busy !== 1'b1) busy_bad = 1'b1;
        h--;
      end else begin
        tx_ready = 1'b1;
        if (tx_valid === 1'b1) begin
          rb[got] = tx_byte;
          rc[got] = tx_cmd;
          got++;
        end
      end
      @(negedge clk);
      t++;
    end
    tx_ready = 1'b1;
  endtask

  task automatic do_result(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           input logic [31:0] er, input logic [3:0] ef, input int hold_n, input string name);
    int got, lat, s0, u0;
    logic [7:0] exp_b [0:4];
    exp_b[0] = er[31:24];
    exp_b[1] = er[23:16];
    exp_b[2] = er[15:8];
    exp_b[3] = er[7:0];
    exp_b[4] = {1'b0, ef, ref_crc3({er, 1'b0, ef})};
    s0 = starts;
    u0 = op_unstable;
    stall_bad = 1'b0;
    busy_bad = 1'b0;
    send_data(a, b);
    send_pkt(1'b1, mk_ctl(a, b, op, 4'b0000));
    recv(5, 2, hold_n, got, lat);
    n_cmp++;
    if (got !== 5) begin n_bad++; $display("FAIL %s count: got %0d bytes want 5", name, got); end
    n_cmp++;
    if (lat !== 4) begin n_bad++; $display("FAIL %s latency: got %0d want 4 (cycles after CHECK)", name, lat); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (rb[i] !== exp_b[i] || rc[i] !== (i == 4)) begin
        n_bad++;
        $display("FAIL %s byte%0d: got %h cmd %b want %h cmd %b", name, i, rb[i], rc[i], exp_b[i], i == 4);
      end
    end
    n_cmp++;
    if (starts - s0 !== 1) begin n_bad++; $display("FAIL %s alu_start: got %0d pulse cycles want 1", name, starts - s0); end
    n_cmp++;
    if (op_unstable !== u0) begin n_bad++; $display("FAIL %s operands: changed %0d times want 0", name, op_unstable - u0); end
    n_cmp++;
    if (stall_bad || busy_bad) begin n_bad++; $display("FAIL %s stall: byte_unstable %b busy_wrong %b want 0 0", name, stall_bad, busy_bad); end
    n_cmp++;
    if ({rx_ready, busy, tx_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL %s return: rx_ready/busy/tx_valid %b want 100", name, {rx_ready, busy, tx_valid});
    end
  endtask

  task automatic do_err(input logic [7:0] exp, input int s0, input string name);
    int got, lat;
    recv(1, 0, 0, got, lat);
    n_cmp++;
    if (got !== 1 || lat !== 1) begin n_bad++; $display("FAIL %s timing: got %0d bytes lat %0d want 1 lat 1", name, got, lat); end
    n_cmp++;
    if (rb[0] !== exp || rc[0] !== 1'b1) begin n_bad++; $display("FAIL %s byte: got %h cmd %b want %h cmd 1", name, rb[0], rc[0], exp); end
    n_cmp++;
    if (starts !== s0) begin n_bad++; $display("FAIL %s alu_start: got %0d pulses want 0", name, starts - s0); end
    n_cmp++;
    if ({rx_ready, busy, tx_valid} !== 3'b100) begin
      n_bad++;
      $display("FAIL %s return: rx_ready/busy/tx_valid %b want 100", name, {rx_ready, busy, tx_valid});
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({rx_ready, busy, tx_valid, alu_start, tx_cmd} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset ctrl: got %b want 10000", {rx_ready, busy, tx_valid, alu_start, tx_cmd});
    end
    n_cmp++;
    if (tx_byte !== 8'h00) begin n_bad++; $display("FAIL reset tx_byte: got %h want 00", tx_byte); end
    n_cmp++;
    if ({alu_a, alu_b, alu_op} !== 67'd0) begin n_bad++; $display("FAIL reset alu: got %h %h %h want 0", alu_a, alu_b, alu_op); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_carry;
    do_result(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b100, 32'hFFFF_FFFE, 4'b1001, 0, "add_carry");
  endtask

  task automatic test_sub_zero;
    do_result(32'h0, 32'h0, 3'b101, 32'h0, 4'b0010, 0, "sub_zero");
  endtask

  task automatic test_logic_ops;
    do_result(32'hF0F0_1234, 32'h0FF0_FF00, 3'b000, 32'h00F0_1200, 4'b0000, 0, "and");
    do_result(32'hF0F0_1234, 32'h0FF0_FF00, 3'b001, 32'hFFF0_FF34, 4'b0001, 0, "or");
  endtask

  task automatic test_flags;
    do_result(32'h7FFF_FFFF, 32'h1, 3'b100, 32'h8000_0000, 4'b0101, 0, "add_ovf");
    do_result(32'h3, 32'h5, 3'b101, 32'hFFFF_FFFE, 4'b1001, 0, "sub_borrow");
  endtask

  task automatic test_crc_err;
    int s0;
    s0 = starts;
    send_data(32'd5, 32'd2);
    send_pkt(1'b1, mk_ctl(32'd5, 32'd2, 3'b100, 4'b0001));
    do_err(8'hA5, s0, "crc_err");
  endtask

  task automatic test_data_err;
    int s0;
    s0 = starts;
    send_pkt(1'b0, 8'h11);
    send_pkt(1'b0, 8'h22);
    send_pkt(1'b1, 8'h50);
    do_err(8'hC9, s0, "data_two");
    for (int i = 0; i < 7; i++) send_pkt(1'b0, 8'h30 + 8'(i));
    send_pkt(1'b1, 8'h40);
    do_err(8'hC9, s0, "data_seven");
    for (int i = 0; i < 16; i++) send_pkt(1'b0, 8'hE0 + 8'(i));
    send_data(32'h0102_0304, 32'h0506_0708);
    send_pkt(1'b1, mk_ctl(32'h0102_0304, 32'h0506_0708, 3'b100, 4'b0000));
    do_err(8'hC9, s0, "data_saturate");
  endtask

  task automatic test_op_err;
    int s0;
    s0 = starts;
    send_data(32'h0102_0304, 32'h0A0B_0C0D);
    send_pkt(1'b1, mk_ctl(32'h0102_0304, 32'h0A0B_0C0D, 3'b010, 4'b0000));
    do_err(8'h93, s0, "op_010");
    send_data(32'hDEAD_BEEF, 32'h1234_5678);
    send_pkt(1'b1, mk_ctl(32'hDEAD_BEEF, 32'h1234_5678, 3'b111, 4'b0000));
    do_err(8'h93, s0, "op_111");
  endtask

  task automatic test_priority;
    int s0;
    s0 = starts;
    send_data(32'h0102_0304, 32'h0A0B_0C0D);
    send_pkt(1'b1, mk_ctl(32'h0102_0304, 32'h0A0B_0C0D, 3'b011, 4'b1000));
    do_err(8'hA5, s0, "crc_over_op");
    send_pkt(1'b0, 8'h55);
    send_pkt(1'b1, mk_ctl(32'h0, 32'h0, 3'b011, 4'b0110));
    do_err(8'hC9, s0, "data_over_all");
  endtask

  task automatic test_stall;
    do_result(32'h1234_5678, 32'h1111_1111, 3'b100, 32'h2345_6789, 4'b0000, 20, "stall");
  endtask

  task automatic test_back_to_back;
    int s0;
    do_result(32'h0000_0010, 32'h0000_0020, 3'b001, 32'h0000_0030, 4'b0000, 0, "b2b_first");
    s0 = starts;
    send_pkt(1'b1, 8'h43);
    do_err(8'hC9, s0, "b2b_cmd_on_entry");
    do_result(32'h8000_0000, 32'h8000_0000, 3'b100, 32'h0, 4'b1110, 0, "b2b_after_err");
  endtask

  task automatic test_reset_mid_tx;
    int got, lat, seen;
    send_data(32'h0102_0304, 32'h1020_3040);
    send_pkt(1'b1, mk_ctl(32'h0102_0304, 32'h1020_3040, 3'b100, 4'b0000));
    recv(2, 0, 0, got, lat);
    tx_ready = 1'b0;
    n_cmp++;
    if (got !== 2 || tx_valid !== 1'b1 || tx_byte !== 8'h33 || tx_cmd !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid byte3: got %0d bytes valid %b byte %h cmd %b want 2 1 33 0", got, tx_valid, tx_byte, tx_cmd);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({tx_valid, rx_ready, busy, tx_cmd} !== 4'b0100 || tx_byte !== 8'h00 || alu_a !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_mid async: valid/ready/busy/cmd %b byte %h alu_a %h want 0100 00 0", {tx_valid, rx_ready, busy, tx_cmd}, tx_byte, alu_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tx_ready = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (tx_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL rst_mid reissue: got %0d tx_valid cycles want 0", seen); end
    do_result(32'hA, 32'h3, 3'b101, 32'h7, 4'b0000, 0, "after_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_add_carry;
    test_sub_zero;
    test_logic_ops;
    test_flags;
    test_crc_err;
    test_data_err;
    test_op_err;
    test_priority;
    test_stall;
    test_back_to_back;
    test_reset_mid_tx;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
